fifo_stream_reader: RTL and testbench

Downstream drain stage for the synchronous FIFO. Pulls words out of the FIFO read port (rd / READ_DATA / EMPTY), holds them in a 2-entry output buffer and presents them on a valid/ready stream with packet framing (out_last every PKT_LEN words). It guarantees the FIFO never sees a read while EMPTY, so UNDERFLOW never fires, and sustains one word per cycle when the consumer keeps out_ready high.

---
 rtl/fifo_stream_reader_if.sv | 24 ++
 rtl/fifo_stream_reader.sv | 74 +++++++
 tb/tb_fifo_stream_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the framed output stream of the drain stage.
// The master modport is the reader's view; the slave modport is the FIFO and consumer side.
interface fifo_stream_reader_if #(
  parameter int W_DATA = 8
);
  logic              fifo_empty;
  logic [W_DATA-1:0] fifo_rd_data;
  logic              fifo_rd;
  logic [W_DATA-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [7:0]        pkt_count;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd, out_data, out_valid, out_last, pkt_count
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd, out_data, out_valid, out_last, pkt_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a 2-entry buffer and presents it as a framed
// valid/ready stream, never reading the FIFO while it is empty.
module fifo_stream_reader #(
  parameter int W_DATA  = 8,
  parameter int PKT_LEN = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fifo_stream_reader_if.master bus
);
  localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [W_DATA-1:0] entry_q [2];
  logic [W_DATA-1:0] entry_d [2];
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [7:0]        pktCount_q, pktCount_d;

  logic       pop;
  logic       isLast;
  logic       rdReq;
  logic       tailIdx;
  logic [2:0] pending;

  // Reads are requested only while buffered plus in-flight words, after this
  // cycle's pop, leave room; that keeps occ + inflight <= 2 at all times.
  always_comb begin
    pop      = (occ_q != 2'd0) && bus.out_ready;
    isLast   = (beat_q == LAST_BEAT);
    pending  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    rdReq    = rst_ni && !bus.fifo_empty && (pending < 3'd2);
    tailIdx  = occ_q[0] ^ pop;

    entry_d    = entry_q;
    occ_d      = pending[1:0];
    beat_d     = beat_q;
    pktCount_d = pktCount_q;

    if (pop) begin
      entry_d[0] = entry_q[1];
      entry_d[1] = '0;
      beat_d     = isLast ? '0 : beat_q + BEAT_W'(1);
      pktCount_d = pktCount_q + {7'd0, isLast};
    end
    if (inflight_q) begin
      entry_d[tailIdx] = bus.fifo_rd_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      pktCount_q <= 8'd0;
    end else begin
      entry_q    <= entry_d;
      occ_q      <= occ_d;
      inflight_q <= rdReq;
      beat_q     <= beat_d;
      pktCount_q <= pktCount_d;
    end
  end

  assign bus.fifo_rd   = rdReq;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = entry_q[0];
  assign bus.out_last  = (occ_q != 2'd0) && isLast;
  assign bus.pkt_count = pktCount_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a queue-based FIFO feeds the reader while a word-count
// model predicts the stream, framing and read strobe every cycle.
module tb_fifo_stream_reader;
  localparam int W_DATA  = 8;
  localparam int PKT_LEN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.W_DATA(W_DATA)) bus ();

  fifo_stream_reader #(.W_DATA(W_DATA), .PKT_LEN(PKT_LEN)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } acc_t;

  logic [7:0] fifoQ[$];
  logic [7:0] readQ[$];
  acc_t       acceptLog[$];
  int         acceptCycle[$];
  bit         fifoEmpty = 1'b1;
  bit         inflightM, rdS, popS, lastS;
  logic [7:0] dataS;
  int         arrived, accepted, rdPulses, cycle;
  int         checks = 0;
  int         passes = 0;

  assign bus.fifo_empty = fifoEmpty;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    fifoQ.push_back(word);
    fifoEmpty = (fifoQ.size() == 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Expected outputs follow from word counts alone: words read but not yet
  // accepted, how many of those have landed, and how many were accepted.
  always @(negedge clk) begin
    bit expValid;
    cycle++;
    rdS  = 1'b0;
    popS = 1'b0;
    if (!rst_n) begin
      readQ.delete();
      arrived   = 0;
      accepted  = 0;
      inflightM = 1'b0;
      checkOutput("reset fifo_rd", bus.fifo_rd, 0);
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset out_last", bus.out_last, 0);
      checkOutput("reset out_data", bus.out_data, 0);
      checkOutput("reset pkt_count", bus.pkt_count, 0);
    end else begin
      expValid = (arrived > 0);
      checkOutput("out_valid", bus.out_valid, expValid);
      if (expValid) begin
        checkOutput("out_data", bus.out_data, readQ[0]);
        checkOutput("out_last", bus.out_last, (accepted % PKT_LEN) == PKT_LEN - 1);
      end else begin
        checkOutput("out_last idle", bus.out_last, 0);
      end
      checkOutput("pkt_count", bus.pkt_count, (accepted / PKT_LEN) % 256);
      checkOutput("fifo_rd",  bus.fifo_rd,
                  !fifoEmpty && (readQ.size() - int'(expValid && bus.out_ready)) < 2);
      checkOutput("no rd while empty", bus.fifo_rd && fifoEmpty, 0);
      checkOutput("outstanding bound", readQ.size() <= 2, 1);
      rdS   = bus.fifo_rd;
      popS  = bus.out_valid && bus.out_ready;
      lastS = bus.out_last;
      dataS = bus.out_data;
    end
  end

  // Advance the model and the FIFO on each edge; read data appears one cycle later.
  always @(posedge clk) begin
    logic [7:0] w;
    bit         gotWord;
    gotWord = 1'b0;
    if (popS) begin
      acceptLog.push_back({lastS, dataS});
      acceptCycle.push_back(cycle);
      void'(readQ.pop_front());
      arrived--;
      accepted++;
    end
    if (inflightM) arrived++;
    inflightM = rdS;
    if (rdS && fifoQ.size() > 0) begin
      rdPulses++;
      w = fifoQ.pop_front();
      readQ.push_back(w);
      gotWord = 1'b1;
    end
    rdS  = 1'b0;
    popS = 1'b0;
    #1;
    if (gotWord) bus.fifo_rd_data = w;
    fifoEmpty = (fifoQ.size() == 0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.out_ready    = 1'b0;
    bus.fifo_rd_data = '0;
    rst_n            = 1'b0;
    tick(1);
    applyStimulus(8'h11);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      #3;
      checkOutput("hold fifo_rd", bus.fifo_rd, 0);
      checkOutput("hold out_valid", bus.out_valid, 0);
      checkOutput("hold pkt_count", bus.pkt_count, 0);
    end

    tick(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #3 checkOutput("latency rd cycle0", bus.fifo_rd, 1);
    tick(1);
    #3 checkOutput("latency valid cycle1", bus.out_valid, 0);
    tick(1);
    #3 checkOutput("latency valid cycle2", bus.out_valid, 1);
    checkOutput("latency data cycle2", bus.out_data, 8'h11);
    tick(3);

    applyReset();
    acceptLog.delete();
    acceptCycle.delete();
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    tick(14);
    checkOutput("stream count", acceptLog.size(), 8);
    for (int i = 0; i < 8 && i < acceptLog.size(); i++) begin
      checkOutput("stream data", acceptLog[i].data, i + 1);
      checkOutput("stream last", acceptLog[i].last, (i == 3) || (i == 7));
    end
    if (acceptCycle.size() == 8)
      checkOutput("stream back-to-back", acceptCycle[7] - acceptCycle[0], 7);
    checkOutput("stream pkt_count", bus.pkt_count, 2);

    bus.out_ready = 1'b0;
    applyReset();
    rdPulses = 0;
    acceptLog.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'h21 + 8'(i));
    tick(10);
    #3 checkOutput("backpressure rd pulses", rdPulses, 2);
    checkOutput("backpressure valid", bus.out_valid, 1);
    checkOutput("backpressure head", bus.out_data, 8'h21);
    bus.out_ready = 1'b1;
    tick(12);
    checkOutput("release rd pulses", rdPulses, 6);
    checkOutput("release count", acceptLog.size(), 6);
    for (int i = 0; i < 6 && i < acceptLog.size(); i++)
      checkOutput("release order", acceptLog[i].data, 8'h21 + 8'(i));

    applyReset();
    rdPulses = 0;
    acceptLog.delete();
    tick(4);
    checkOutput("empty no rd", rdPulses, 0);
    applyStimulus(8'hA5);
    tick(6);
    checkOutput("single rd pulse", rdPulses, 1);
    checkOutput("single count", acceptLog.size(), 1);
    if (acceptLog.size() > 0) checkOutput("single data", acceptLog[0].data, 8'hA5);

    bus.out_ready = 1'b0;
    applyReset();
    acceptLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(8'h31 + 8'(i));
    tick(5);
    bus.out_ready = 1'b1;
    tick(2);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #3 checkOutput("mid count", acceptLog.size(), 2);
    if (acceptLog.size() == 2) begin
      checkOutput("mid first", acceptLog[0].data, 8'h31);
      checkOutput("mid second", acceptLog[1].data, 8'h32);
    end
    checkOutput("mid valid cleared", bus.out_valid, 0);
    checkOutput("mid data cleared", bus.out_data, 0);
    tick(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    acceptLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(8'h41 + 8'(i));
    tick(12);
    checkOutput("after reset count", acceptLog.size(), 4);
    for (int i = 0; i < 4 && i < acceptLog.size(); i++) begin
      checkOutput("after reset data", acceptLog[i].data, 8'h41 + 8'(i));
      checkOutput("after reset last", acceptLog[i].last, i == 3);
    end
    checkOutput("after reset pkt_count", bus.pkt_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
